mux4_arbiter: RTL and testbench
===============================

MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum consecutive grant cycles per owner (legal 2..255); used only when ARB_TIMEOUT_EN is defined.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  4  per-requester request, level, bit i = requester i.
REQ-005 DONE  input  4  per-requester release strobe; only the current owner's bit is honoured.
REQ-006 D0, D1, D2, D3  input  32 each  requester data.
REQ-007 GNT  output  4  one-hot grant, registered; all-zero when no owner.
REQ-008 SEL  output  2  index of current or most recent owner, registered; drives downstream 4:1 mux select.
REQ-009 Y  output  32  registered copy of D[SEL].
REQ-010 VALID  output  1  high when Y holds data captured during a grant.
REQ-011 TOUT  output  1  one-cycle forced-release pulse; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-012 FSM SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-013 In IDLE with REQ != 0, arbiter SHALL pick the first set REQ bit scanning from (LAST+1) mod 4 upward with wrap 3->0, where LAST is the previous owner index.
REQ-014 Pick SHALL take effect at the next edge: GNT = one-hot(pick), SEL = pick, LAST = pick, state = BUSY; grant latency is exactly 1 cycle from REQ sampled.
REQ-015 In IDLE with REQ == 0, GNT SHALL stay 0 and SEL, LAST and Y SHALL hold.
REQ-016 In BUSY, grant SHALL hold while REQ[SEL]=1 and DONE[SEL]=0, regardless of other REQ bits.
REQ-017 In BUSY, if DONE[SEL]=1 or REQ[SEL]=0, next edge SHALL clear GNT and enter IDLE; the next grant follows no earlier than one IDLE cycle later.
REQ-018 DONE bits of non-owners SHALL be ignored; DONE in IDLE SHALL be ignored.
REQ-019 In every BUSY cycle, Y SHALL capture D[SEL] at the edge and VALID SHALL be set at the same edge; this includes the release cycle.
REQ-020 In the first IDLE cycle, VALID SHALL clear at the edge; Y SHALL hold its last value.
REQ-021 GNT SHALL never have more than one bit set; SEL SHALL always equal the index of the GNT bit when GNT != 0.
REQ-022 If all four requesters hold REQ continuously and release after one cycle each, grants SHALL rotate 0,1,2,3,0.

Reset
REQ-023 RST_N=0 SHALL immediately force state=IDLE, GNT=0, SEL=0, Y=0, VALID=0, TOUT=0, LAST=3, timeout counter=0, independent of CLK.
REQ-024 Reset asserted in BUSY SHALL drop the grant without a TOUT pulse; after release, requester 0 has highest priority.
REQ-025 The first edge after RST_N rises SHALL perform normal IDLE arbitration.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN, when defined, SHALL add a grant-cycle counter that is cleared on entry to BUSY and increments each BUSY cycle.
REQ-027 With ARB_TIMEOUT_EN, when the counter reaches TIMEOUT-1 in BUSY without a release, the next edge SHALL force IDLE, clear GNT, and pulse TOUT high for exactly one cycle.
REQ-028 With ARB_TIMEOUT_EN, a normal release and the timeout in the same cycle SHALL produce a release only, with TOUT=0.
REQ-029 Without ARB_TIMEOUT_EN, no counter SHALL exist, TOUT SHALL be tied 0, and grants SHALL be unbounded.

Verification
REQ-030 Reset, then REQ=4'b0100 and D2=32'hDEADBEEF: cycle+1 GNT=4'b0100, SEL=2; cycle+2 Y=32'hDEADBEEF, VALID=1.
REQ-031 REQ=4'b1111 held, each owner pulses DONE one cycle after its grant: grant order is 0,1,2,3,0, with one IDLE cycle (GNT=0) between grants.
REQ-032 Owner 1 granted with REQ=4'b1011 and DONE=4'b1000 pulsed: grant to 1 is unchanged; after DONE[1], the next grant goes to 3.
REQ-033 RST_N driven low mid-cycle during BUSY: GNT, Y and VALID are 0 before the next edge; after reset, REQ=4'b1010 gives a grant to 1.
REQ-034 ARB_TIMEOUT_EN defined, TIMEOUT=4, owner 0 never releases: GNT=0 after the 4th BUSY cycle, TOUT is high for one cycle, and the next grant goes to a waiting requester 2.
REQ-035 ARB_TIMEOUT_EN undefined, owner holds for 300 cycles: GNT stays constant and TOUT stays 0.

Source files
------------

// File: rtl/mux4_arbiter.sv
// Four-requester round-robin arbiter with a registered 4:1 data mux behind the grant.
// Optional per-owner grant limit is compiled in with ARB_TIMEOUT_EN.
module mux4_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [31:0] y,
  output logic        valid,
  output logic        tout
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mux4_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [1:0]  last_q;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        found;
  logic [31:0] d_sel;
  logic        release_now;
  logic        timeout_hit;

  // Round-robin scan starting just after the previous owner; k = 4 wraps back to last_q.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    d_sel = d0;
    unique case (sel)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  assign release_now = done[sel] | ~req[sel];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  assign tout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      last_q  <= 2'd3;
      y       <= 32'd0;
      valid   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tout    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tout <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          valid <= 1'b0;
          if (found) begin
            state_q <= StBusy;
            gnt     <= 4'b0001 << pick;
            sel     <= pick;
            last_q  <= pick;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        StBusy: begin
          // Data is captured on every owned cycle, including the releasing one.
          y     <= d_sel;
          valid <= 1'b1;
          if (release_now || timeout_hit) begin
            state_q <= StIdle;
            gnt     <= 4'b0000;
          end
`ifdef ARB_TIMEOUT_EN
          // A normal release wins over a coincident timeout and suppresses the pulse.
          if (!release_now && timeout_hit) begin
            tout <= 1'b1;
          end else if (!release_now) begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          gnt     <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus randomized traffic
// compared against an index-based reference model.
module tb_mux4_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TbTimeout = 4;
`else
  localparam int TbTimeout = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [31:0] d [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] y;
  logic        valid;
  logic        tout;

  int n_tests;
  int n_fail;

  // Reference model state: owner index or -1 when nobody holds the grant.
  int          m_owner;
  int          m_last;
  int          m_sel;
  int          m_cnt;
  logic [31:0] m_y;
  logic        m_valid;
  logic        m_tout;

  mux4_arbiter #(.TIMEOUT(TbTimeout)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .done (done),
    .d0   (d[0]),
    .d1   (d[1]),
    .d2   (d[2]),
    .d3   (d[3]),
    .gnt  (gnt),
    .sel  (sel),
    .y    (y),
    .valid(valid),
    .tout (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_cnt   = 0;
    m_y     = 32'd0;
    m_valid = 1'b0;
    m_tout  = 1'b0;
  endfunction

  function automatic void model_step();
    int cand;
    m_tout = 1'b0;
    if (m_owner < 0) begin
      m_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        cand = (m_last + k) % 4;
        if (m_owner < 0 && req[cand]) begin
          m_owner = cand;
          m_sel   = cand;
          m_last  = cand;
          m_cnt   = 0;
        end
      end
    end else begin
      m_y     = d[m_owner];
      m_valid = 1'b1;
      if (done[m_owner] || !req[m_owner]) begin
        m_owner = -1;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_cnt == TbTimeout - 1) begin
          m_owner = -1;
          m_tout  = 1'b1;
        end else begin
          m_cnt++;
        end
`else
        m_cnt++;
`endif
      end
    end
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req  = 4'b0000;
    done = 4'b0000;
    for (int i = 0; i < 4; i++) d[i] = 32'h1000_0000 + 32'(i);
    apply_reset();
    n_tests++;
    if ({gnt, sel, valid, tout} !== 8'b0 || y !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b sel=%0d y=%h valid=%b tout=%b, want all zero",
               gnt, sel, y, valid, tout);
    end
    repeat (3) tick();
    n_tests++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || y !== 32'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: gnt=%b sel=%0d y=%h valid=%b, want 0/0/0/0",
               gnt, sel, y, valid);
    end
  endtask

  task automatic test_single_grant();
    apply_reset();
    d[2] = 32'hDEADBEEF;
    req  = 4'b0100;
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b sel=%0d, want 0100/2", gnt, sel);
    end
    tick();
    n_tests++;
    if (y !== 32'hDEADBEEF || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_data: y=%h valid=%b, want deadbeef/1", y, valid);
    end
    req = 4'b0000;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b valid=%b, want 0000/1", gnt, valid);
    end
    d[2] = 32'h0;
    tick();
    n_tests++;
    if (valid !== 1'b0 || y !== 32'hDEADBEEF || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL idle_after_release: valid=%b y=%h sel=%0d, want 0/deadbeef/2",
               valid, y, sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      want = 4'b0001 << (k % 4);
      tick();
      n_tests++;
      if (gnt !== want || sel !== 2'(k % 4)) begin
        n_fail++;
        $display("FAIL rotation_grant[%0d]: gnt=%b sel=%0d, want %b/%0d",
                 k, gnt, sel, want, k % 4);
      end
      done = want;
      tick();
      done = 4'b0000;
      n_tests++;
      if (gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rotation_gap[%0d]: gnt=%b, want 0000", k, gnt);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_ignore_done();
    apply_reset();
    req = 4'b0010;
    tick();
    req  = 4'b1011;
    done = 4'b1000;
    repeat (3) tick();
    n_tests++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL nonowner_done: gnt=%b sel=%0d, want 0010/1", gnt, sel);
    end
    done = 4'b0010;
    tick();
    done = 4'b0000;
    n_tests++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL owner_done: gnt=%b, want 0000", gnt);
    end
    done = 4'b1111;
    tick();
    done = 4'b0000;
    n_tests++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_fail++;
      $display("FAIL next_after_1: gnt=%b sel=%0d, want 1000/3", gnt, sel);
    end
    req = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    d[0] = 32'hA5A5_0001;
    req  = 4'b0001;
    repeat (2) tick();
    n_tests++;
    if (gnt !== 4'b0001 || valid !== 1'b1 || y !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL busy_before_reset: gnt=%b valid=%b y=%h, want 0001/1/a5a50001",
               gnt, valid, y);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || y !== 32'd0 || valid !== 1'b0 || tout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: gnt=%b y=%h valid=%b tout=%b, want all zero",
               gnt, y, valid, tout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL post_reset_pick: gnt=%b sel=%0d, want 0010/1", gnt, sel);
    end
    req = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      tick();
      n_tests++;
      if (gnt !== m_gnt() || sel !== 2'(m_sel) || tout !== m_tout) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: gnt=%b sel=%0d tout=%b, want %b/%0d/%b",
                 c, gnt, sel, tout, m_gnt(), m_sel, m_tout);
      end
      n_tests++;
      if (y !== m_y || valid !== m_valid) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: y=%h valid=%b, want %h/%b", c, y, valid, m_y, m_valid);
      end
    end
    req  = 4'b0000;
    done = 4'b0000;
    repeat (2) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req = 4'b0101;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL to_grant: gnt=%b, want 0001", gnt);
    end
    repeat (3) tick();
    n_tests++;
    if (gnt !== 4'b0001 || tout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_hold: gnt=%b tout=%b, want 0001/0", gnt, tout);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || tout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_fire: gnt=%b tout=%b, want 0000/1", gnt, tout);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0100 || tout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_next: gnt=%b tout=%b, want 0100/0", gnt, tout);
    end
    // Release coinciding with the limit: release only, no pulse.
    repeat (3) tick();
    done = 4'b0100;
    tick();
    done = 4'b0000;
    n_tests++;
    if (gnt !== 4'b0000 || tout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_coincide: gnt=%b tout=%b, want 0000/0", gnt, tout);
    end
    req = 4'b0000;
    repeat (2) tick();
  endtask
`else
  task automatic test_long_hold();
    apply_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 300; c++) begin
      tick();
      n_tests++;
      if (gnt !== 4'b0001 || tout !== 1'b0) begin
        n_fail++;
        $display("FAIL long_hold[%0d]: gnt=%b tout=%b, want 0001/0", c, gnt, tout);
      end
    end
    req = 4'b0000;
    repeat (2) tick();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    done    = 4'b0000;
    model_reset();
    test_reset();
    test_single_grant();
    test_rotation();
    test_ignore_done();
    test_async_reset();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
